// File: rtl/axi_wr_burst_cmd.sv
// AXI4 write-side slave front end: queues AW commands, expands each burst into
// a flat per-beat {id, addr, strb, data, last} command stream and returns B responses.
module axi_wr_burst_cmd #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AW_DEPTH = 4,
    parameter int unsigned B_DEPTH  = 4
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [ID_W-1:0]                        AWID_i,
    input  logic [ADDR_W-1:0]                      AWADDR_i,
    input  logic [7:0]                             AWLEN_i,
    input  logic [2:0]                             AWSIZE_i,
    input  logic [1:0]                             AWBURST_i,
    input  logic                                   AWVALID_i,
    output logic                                   AWREADY_o,
    input  logic [DATA_W-1:0]                      WDATA_i,
    input  logic [DATA_W/8-1:0]                    WSTRB_i,
    input  logic                                   WLAST_i,
    input  logic                                   WVALID_i,
    output logic                                   WREADY_o,
    output logic [ID_W-1:0]                        BID_o,
    output logic [1:0]                             BRESP_o,
    output logic                                   BVALID_o,
    input  logic                                   BREADY_i,
    output logic                                   cmd_vld_o,
    input  logic                                   cmd_rdy_i,
    output logic [ID_W+ADDR_W+DATA_W/8+DATA_W:0]   cmd_payload_o
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned MAX_SIZE = $clog2(STRB_W);
    localparam int unsigned AW_PW    = $clog2(AW_DEPTH);
    localparam int unsigned B_PW     = $clog2(B_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_t;

    typedef enum logic {IDLE, DATA} state_t;

    // ---------------- AW outstanding FIFO ----------------
    aw_t              aw_mem [AW_DEPTH];
    logic [AW_PW-1:0] aw_wp, aw_rp;
    logic [AW_PW:0]   aw_cnt;
    logic             aw_full, aw_empty, aw_push, aw_pop;
    aw_t              aw_head;

    assign aw_full   = (aw_cnt == (AW_PW+1)'(AW_DEPTH));
    assign aw_empty  = (aw_cnt == '0);
    assign AWREADY_o = !aw_full && !ARESET_i;
    assign aw_push   = AWVALID_i && AWREADY_o;
    assign aw_head   = aw_mem[aw_rp];

    always_ff @(posedge ACLK_i) begin
        if (aw_push) aw_mem[aw_wp] <= '{AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i};
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            aw_wp  <= '0;
            aw_rp  <= '0;
            aw_cnt <= '0;
        end else begin
            if (aw_push) aw_wp <= aw_wp + 1'b1;
            if (aw_pop)  aw_rp <= aw_rp + 1'b1;
            case ({aw_push, aw_pop})
                2'b10:   aw_cnt <= aw_cnt + 1'b1;
                2'b01:   aw_cnt <= aw_cnt - 1'b1;
                default: aw_cnt <= aw_cnt;
            endcase
        end
    end

    // ---------------- B response FIFO ----------------
    b_t              b_mem [B_DEPTH];
    logic [B_PW-1:0] b_wp, b_rp;
    logic [B_PW:0]   b_cnt;
    logic            b_full, b_empty, b_push, b_pop;
    b_t              b_wdata;

    assign b_full   = (b_cnt == (B_PW+1)'(B_DEPTH));
    assign b_empty  = (b_cnt == '0);
    assign BVALID_o = !b_empty && !ARESET_i;
    assign BID_o    = b_mem[b_rp].id;
    assign BRESP_o  = b_mem[b_rp].resp;
    assign b_pop    = BVALID_o && BREADY_i;

    always_ff @(posedge ACLK_i) begin
        if (b_push) b_mem[b_wp] <= b_wdata;
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            b_wp  <= '0;
            b_rp  <= '0;
            b_cnt <= '0;
        end else begin
            if (b_push) b_wp <= b_wp + 1'b1;
            if (b_pop)  b_rp <= b_rp + 1'b1;
            case ({b_push, b_pop})
                2'b10:   b_cnt <= b_cnt + 1'b1;
                2'b01:   b_cnt <= b_cnt - 1'b1;
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    // ---------------- Burst engine ----------------
    state_t            state, state_nx;
    logic [ID_W-1:0]   bu_id;
    logic [ADDR_W-1:0] bu_addr;
    logic [7:0]        bu_len;
    logic [2:0]        bu_size;
    logic [1:0]        bu_burst;
    logic [7:0]        beat_cnt;
    logic              err;
    logic              load, beat_acc, beat_last, wlast_err;
    logic              head_size_err, head_wrap_bad;

    // Size clamp and WRAP->INCR fallback are resolved at load so the address path stays simple
    assign head_size_err = (aw_head.size > 3'(MAX_SIZE));
    assign head_wrap_bad = (aw_head.burst == 2'b10) &&
                           !(aw_head.len inside {8'd1, 8'd3, 8'd7, 8'd15});

    assign WREADY_o  = (state == DATA) && cmd_rdy_i && !ARESET_i;
    assign cmd_vld_o = (state == DATA) && WVALID_i && !ARESET_i;
    assign beat_acc  = WVALID_i && WREADY_o;
    assign beat_last = (beat_cnt == bu_len);
    assign wlast_err = (WLAST_i != beat_last);
    assign aw_pop    = load;
    assign b_push    = beat_acc && beat_last;
    assign b_wdata   = '{bu_id, (err || wlast_err) ? 2'b10 : 2'b00};

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: if (!aw_empty && !b_full) begin
                load     = 1'b1;
                state_nx = DATA;
            end
            DATA: if (beat_acc && beat_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            err      <= 1'b0;
            bu_id    <= '0;
            bu_addr  <= '0;
            bu_len   <= '0;
            bu_size  <= '0;
            bu_burst <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                bu_id    <= aw_head.id;
                bu_addr  <= aw_head.addr;
                bu_len   <= aw_head.len;
                bu_size  <= head_size_err ? 3'(MAX_SIZE) : aw_head.size;
                bu_burst <= head_wrap_bad ? 2'b01 : aw_head.burst;
                beat_cnt <= '0;
                err      <= head_size_err || head_wrap_bad;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
                err      <= err || wlast_err;
            end
        end
    end

    // ---------------- Beat address ----------------
    logic [ADDR_W-1:0] bytes, n_off, total, wmask, beat_addr;

    always_comb begin
        bytes = ADDR_W'(1) << bu_size;
        n_off = ADDR_W'(beat_cnt) << bu_size;
        total = (ADDR_W'(bu_len) + ADDR_W'(1)) << bu_size;
        wmask = total - ADDR_W'(1);
        case (bu_burst)
            2'b00:   beat_addr = bu_addr;
            2'b10:   beat_addr = (bu_addr & ~wmask) | ((bu_addr + n_off) & wmask);
            default: beat_addr = (beat_cnt == '0) ? bu_addr
                                                  : (bu_addr & ~(bytes - ADDR_W'(1))) + n_off;
        endcase
    end

    assign cmd_payload_o = {bu_id, beat_addr, WSTRB_i, WDATA_i, beat_last};

endmodule

// File: tb/tb_axi_wr_burst_cmd.sv
// Scoreboard bench for axi_wr_burst_cmd: expected beats/B responses are queued
// as W/AW stimulus is driven and checked when the DUT hands them off.
module tb_axi_wr_burst_cmd;

    localparam int ID_W = 4, ADDR_W = 12, DATA_W = 32;
    localparam int PW = ID_W + ADDR_W + DATA_W/8 + DATA_W + 1;
    localparam int FIXED = 0, INCR = 1, WRAP = 2;

    logic              clk = 1'b0;
    logic              areset;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast, wvalid, wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic              cmd_vld, cmd_rdy;
    logic [PW-1:0]     cmd_payload;

    int n_checks = 0;
    int n_pass   = 0;
    bit toggle_en = 1'b0;

    logic [PW-1:0]     exp_cmd[$];
    logic [ID_W+1:0]   exp_b[$];

    axi_wr_burst_cmd #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AW_DEPTH(4), .B_DEPTH(4)) dut (
        .ACLK_i(clk), .ARESET_i(areset),
        .AWID_i(awid), .AWADDR_i(awaddr), .AWLEN_i(awlen), .AWSIZE_i(awsize),
        .AWBURST_i(awburst), .AWVALID_i(awvalid), .AWREADY_o(awready),
        .WDATA_i(wdata), .WSTRB_i(wstrb), .WLAST_i(wlast), .WVALID_i(wvalid), .WREADY_o(wready),
        .BID_o(bid), .BRESP_o(bresp), .BVALID_o(bvalid), .BREADY_i(bready),
        .cmd_vld_o(cmd_vld), .cmd_rdy_i(cmd_rdy), .cmd_payload_o(cmd_payload)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference address of beat n, written directly from the burst arithmetic
    function automatic logic [ADDR_W-1:0] ref_addr(input int addr, len, size, burst, n);
        int bytes, total, bnd, eff;
        bytes = 1 << ((size > 2) ? 2 : size);
        eff = burst;
        if (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) eff = INCR;
        if (eff == FIXED) return ADDR_W'(addr);
        if (eff == WRAP) begin
            total = bytes * (len + 1);
            bnd   = addr - (addr % total);
            return ADDR_W'((bnd + ((addr + n * bytes) % total)) % 4096);
        end
        if (n == 0) return ADDR_W'(addr);
        return ADDR_W'(((addr / bytes) * bytes + n * bytes) % 4096);
    endfunction

    // Scoreboard consumer: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk) begin
        if (cmd_vld && cmd_rdy) begin
            if (exp_cmd.size() == 0) check("cmd_extra", 64'(exp_cmd.size()), 64'd1);
            else check("cmd", 64'(cmd_payload), 64'(exp_cmd.pop_front()));
        end
        if (bvalid && bready) begin
            if (exp_b.size() == 0) check("b_extra", 64'(exp_b.size()), 64'd1);
            else check("b", 64'({bid, bresp}), 64'(exp_b.pop_front()));
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (toggle_en) cmd_rdy = ~cmd_rdy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic aw_try(input int id, addr, len, size, burst, budget, output bit acc);
        logic hs;
        awid = ID_W'(id); awaddr = ADDR_W'(addr); awlen = 8'(len);
        awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1;
            if (hs) begin acc = 1'b1; break; end
        end
        awvalid = 1'b0;
    endtask

    task automatic aw_send(input int id, addr, len, size, burst);
        bit acc;
        aw_try(id, addr, len, size, burst, 200, acc);
        check("aw_accept", 64'(acc), 64'd1);
    endtask

    task automatic w_beat(input int id, input logic [ADDR_W-1:0] a, input bit last_m, input bit wl);
        logic hs;
        bit ok;
        logic [DATA_W-1:0] d;
        logic [DATA_W/8-1:0] s;
        d = $urandom; s = 4'($urandom);
        exp_cmd.push_back({ID_W'(id), a, s, d, last_m});
        wdata = d; wstrb = s; wlast = wl; wvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (toggle_en && !cmd_rdy) check("wready_gate", 64'(wready), 64'd0);
            hs = wready;
            @(posedge clk); #1;
            if (hs) begin ok = 1'b1; break; end
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (!ok) begin
            check("w_timeout", 64'(ok), 64'd1);
            void'(exp_cmd.pop_back());
        end
    endtask

    task automatic w_burst(input int id, addr, len, size, burst, bad_n, input bit drop_last);
        bit err;
        err = (size > 2) || (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15))
              || (bad_n >= 0 && bad_n < len) || drop_last;
        exp_b.push_back({ID_W'(id), err ? 2'b10 : 2'b00});
        for (int n = 0; n <= len; n++)
            w_beat(id, ref_addr(addr, len, size, burst, n), n == len,
                   (n == len) ? !drop_last : (n == bad_n));
        @(negedge clk);
        check("bvalid_next", 64'(bvalid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit acc;
        areset = 1'b1; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1; bready = 1'b1; cmd_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_cmd_vld", 64'(cmd_vld), 64'd0);
        @(posedge clk); #1;
        areset = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("awready_post_rst", 64'(awready), 64'd1);
        @(posedge clk); #1;

        // Basic INCR / WRAP / unaligned / FIXED / address wrap-around
        aw_send(1, 'h004, 3, 2, INCR);  w_burst(1, 'h004, 3, 2, INCR, -1, 0);
        aw_send(2, 'h038, 3, 2, WRAP);  w_burst(2, 'h038, 3, 2, WRAP, -1, 0);
        aw_send(3, 'h005, 1, 2, INCR);  w_burst(3, 'h005, 1, 2, INCR, -1, 0);
        aw_send(4, 'h100, 2, 2, FIXED); w_burst(4, 'h100, 2, 2, FIXED, -1, 0);
        aw_send(5, 'hFFC, 1, 2, INCR);  w_burst(5, 'hFFC, 1, 2, INCR, -1, 0);

        // Error cases: early WLAST, bad WRAP length, oversize beat, missing WLAST
        aw_send(6, 'h200, 3, 2, INCR);  w_burst(6, 'h200, 3, 2, INCR, 1, 0);
        aw_send(7, 'h040, 2, 2, WRAP);  w_burst(7, 'h040, 2, 2, WRAP, -1, 0);
        aw_send(8, 'h010, 1, 3, INCR);  w_burst(8, 'h010, 1, 3, INCR, -1, 0);
        aw_send(9, 'h020, 1, 2, INCR);  w_burst(9, 'h020, 1, 2, INCR, -1, 1);

        // AW backpressure: 1 in engine + 4 queued, 6th refused until a burst drains
        for (int i = 0; i < 6; i++) begin
            aw_try(10 + i, 'h300 + 16 * i, 0, 2, INCR, 3, acc);
            check($sformatf("aw_offer%0d", i), 64'(acc), (i < 5) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        check("awready_full", 64'(awready), 64'd0);
        @(posedge clk); #1;
        w_burst(10, 'h300, 0, 2, INCR, -1, 0);
        aw_send(15, 'h350, 0, 2, INCR);
        for (int i = 1; i < 6; i++) w_burst(10 + i, 'h300 + 16 * i, 0, 2, INCR, -1, 0);

        // B backpressure: four unread responses block the engine
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aw_send(i, 'h400 + 4 * i, 0, 2, INCR);
            w_burst(i, 'h400 + 4 * i, 0, 2, INCR, -1, 0);
        end
        aw_send(4, 'h410, 0, 2, INCR);
        wvalid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("wready_bfull", 64'(wready), 64'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        bready = 1'b1;
        w_burst(4, 'h410, 0, 2, INCR, -1, 0);

        // cmd_rdy toggling every cycle through a long burst
        aw_send(5, 'h480, 7, 2, INCR);
        toggle_en = 1'b1;
        w_burst(5, 'h480, 7, 2, INCR, -1, 0);
        toggle_en = 1'b0;
        @(posedge clk); #1;
        cmd_rdy = 1'b1;

        // Reset mid-burst: burst discarded, no B response
        aw_send(6, 'h500, 3, 2, INCR);
        w_beat(6, ref_addr('h500, 3, 2, INCR, 0), 0, 0);
        w_beat(6, ref_addr('h500, 3, 2, INCR, 1), 0, 0);
        wvalid = 1'b1; areset = 1'b1;
        @(negedge clk);
        check("mid_rst_awready", 64'(awready), 64'd0);
        check("mid_rst_wready",  64'(wready),  64'd0);
        check("mid_rst_cmd_vld", 64'(cmd_vld), 64'd0);
        check("mid_rst_bvalid",  64'(bvalid),  64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        areset = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("awready_after_rst", 64'(awready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            check("no_b_after_rst", 64'(bvalid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        aw_send(7, 'h600, 1, 2, INCR); w_burst(7, 'h600, 1, 2, INCR, -1, 0);

        repeat (4) @(posedge clk);
        #1;
        check("cmd_q_drained", 64'(exp_cmd.size()), 64'd0);
        check("b_q_drained",   64'(exp_b.size()),   64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_cmd.md
Name: axi_wr_burst_cmd

Overview:
Parametrised AXI4 write-side slave front end. It accepts AW commands into an outstanding-command FIFO and expands each burst beat-by-beat into a flat command stream {id, addr, strb, data, last} for the downstream async FIFO. Supports FIXED, INCR and WRAP bursts. It also returns B responses through a response FIFO, with SLVERR on protocol violations.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 12, byte address width
DATA_W, 32, data bus width (8..1024, power of 2)
AW_DEPTH, 4, AW outstanding FIFO depth (power of 2, >=2)
B_DEPTH, 4, B response FIFO depth (power of 2, >=2)

Ports:
ACLK_i  in  1  clock
ARESET_i  in  1  synchronous active-high reset
AWID_i  in  ID_W  write ID
AWADDR_i  in  ADDR_W  start address
AWLEN_i  in  8  beats-1
AWSIZE_i  in  3  log2 bytes/beat
AWBURST_i  in  2  00 FIXED, 01 INCR, 10 WRAP
AWVALID_i  in  1  AW valid
AWREADY_o  out  1  AW ready
WDATA_i  in  DATA_W  write data
WSTRB_i  in  DATA_W/8  byte strobes
WLAST_i  in  1  last beat marker
WVALID_i  in  1  W valid
WREADY_o  out  1  W ready
BID_o  out  ID_W  response ID
BRESP_o  out  2  00 OKAY, 10 SLVERR
BVALID_o  out  1  B valid
BREADY_i  in  1  B ready
cmd_vld_o  out  1  command valid
cmd_rdy_i  in  1  command ready (async FIFO not full)
cmd_payload_o  out  ID_W+ADDR_W+DATA_W/8+DATA_W+1  {id, addr, strb, data, last}, MSB first

Behaviour:
- Reset (ARESET_i=1 at an edge): both FIFOs are emptied, state=IDLE, beat counter=0, error flag=0.
- While ARESET_i is high, AWREADY_o, WREADY_o, BVALID_o and cmd_vld_o are all 0.
- Reset mid-burst: the burst is discarded and no B response is produced.
- AW FIFO:
  - AWREADY_o = !aw_full.
  - Push on AWVALID_i&AWREADY_o.
  - The head is popped when the engine loads it.
- Engine FSM, states IDLE and DATA:
  - IDLE -> DATA when aw FIFO is non-empty and the B FIFO is not full.
  - On that edge, load id/addr/len/size/burst into burst registers, pop the AW FIFO, clear the beat counter and the error flag.
  - DATA -> IDLE on acceptance of beat number len (beat counter == AWLEN).
- W/cmd handshake (combinational pass-through, no storage):
  - WREADY_o = (state==DATA) & cmd_rdy_i.
  - cmd_vld_o = (state==DATA) & WVALID_i.
  - A beat is accepted when WVALID_i&WREADY_o; the beat counter increments.
  - The payload's last bit = (counter==len), derived from AWLEN, never from WLAST_i.
- Latency:
  - AW accepted at edge t; FIFO non-empty in cycle t+1; DATA from edge t+2, so the first WREADY_o is possible in cycle t+2.
  - The last beat accepted at edge t gives BVALID_o=1 in cycle t+1.
- Address of beat n (n=0..len), with bytes=1<<size and aligned=addr & ~(bytes-1):
  - FIXED: addr for every beat.
  - INCR:
    - n=0 gives addr.
    - Otherwise aligned + n*bytes.
    - Truncated to ADDR_W bits, i.e. wrap-around modulo 2^ADDR_W.
  - WRAP:
    - total = bytes*(len+1); boundary = addr & ~(total-1).
    - Beat address = boundary + ((addr + n*bytes) mod total).
- Error detection sets SLVERR for the burst. Each condition is OR'd into the error flag:
  - WLAST_i=1 on a beat with n<len.
  - WLAST_i=0 on beat n=len.
  - AWSIZE_i > log2(DATA_W/8).
  - WRAP with len+1 not in {2,4,8,16}. The addresses are then generated as INCR.
  - Oversize AWSIZE_i: bytes is clamped to DATA_W/8 for address math.
  - Beats are always forwarded regardless of error; the burst length is always AWLEN+1.
- B FIFO:
  - On last-beat acceptance, push {id, error?2'b10:2'b00}. Space is guaranteed by the IDLE->DATA check.
  - BVALID_o = !b_empty; BID_o and BRESP_o show the head.
  - Pop on BVALID_o&BREADY_i.
  - A simultaneous push and pop keeps the count unchanged.
- Simultaneous AW push and engine pop: the count is unchanged; a full FIFO accepts a new AW in the same cycle only if AWREADY_o was high (AWREADY_o is not bypassed combinationally).

Test Plan:
- INCR, AWADDR=0x004, AWSIZE=2, AWLEN=3, cmd_rdy=1 -> cmd addrs 0x004,0x008,0x00C,0x010; last only on the 4th beat; BRESP=00 with BID=AWID one cycle later.
- WRAP, AWADDR=0x038, AWSIZE=2, AWLEN=3 -> addrs 0x038,0x03C,0x030,0x034, OKAY. Then unaligned INCR at 0x005, AWSIZE=2, AWLEN=1 -> 0x005,0x008.
- FIXED, AWADDR=0x100, AWLEN=2 -> three beats at 0x100. Then INCR from 0xFFC (ADDR_W=12), AWLEN=1 -> 0xFFC,0x000.
- WLAST_i asserted on beat 1 of an AWLEN=3 burst -> all 4 beats forwarded, BRESP=10. Then WRAP with AWLEN=2 -> BRESP=10 and INCR addressing.
- W held off with 6 AWs offered (AW_DEPTH=4) -> 5 accepted (1 in engine, 4 in FIFO), then AWREADY_o=0 until the first burst completes. BREADY=0 with B_DEPTH=4 -> after 4 bursts, WREADY_o stays 0 until one B is popped.
- cmd_rdy_i toggling every cycle mid-burst -> WREADY_o tracks it and no beat is lost or duplicated. Then assert ARESET_i mid-burst -> no B response, BVALID_o=0, and AWREADY_o=1 the cycle after reset is released.
